mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  input  1  single clock for the block; all state changes on the rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 if_ce_i  input  1  instruction fetch request; held high until if_done_o is seen.
REQ-004 if_addr_i  input  32  fetch byte address; bits [1:0] are ignored.
REQ-005 if_data_o  output  32  fetched word, little-endian; valid while if_done_o is high.
REQ-006 if_done_o  output  1  one-cycle completion pulse for a fetch.
REQ-007 mem_ce_i  input  1  data request; held high until mem_done_o is seen.
REQ-008 mem_we_i  input  1  1 = write, 0 = read.
REQ-009 mem_addr_i  input  32  data byte address; bits [1:0] are ignored.
REQ-010 mem_sel_i  input  4  byte-lane enables; bit k maps to byte k of the word.
REQ-011 mem_data_i  input  32  write data.
REQ-012 mem_data_o  output  32  read word; valid while mem_done_o is high.
REQ-013 mem_done_o  output  1  one-cycle completion pulse for a data access.
REQ-014 stallreq_o  output  1  pipeline stall request to ctrl; combinational.
REQ-015 ram_a_o  output  32  external byte-wide memory address.
REQ-016 ram_dout_o  output  8  external write byte.
REQ-017 ram_din_i  input  8  external read byte; valid one cycle after its address is driven.
REQ-018 ram_wr_o  output  1  external write strobe, one byte per cycle.

Function
REQ-019 Block SHALL be the responder for the core's ROM and RAM ports, serialising each 32-bit access into four byte transfers.
REQ-020 FSM states SHALL be IDLE, RD, WR and DONE; the state register resets to IDLE.
REQ-021 IDLE SHALL sample both requests at each edge: mem_ce_i wins over if_ce_i; a fetch sampled together with a data request stays pending.
REQ-022 Byte counter cnt SHALL run 0..3; during RD/WR step k, ram_a_o = {addr[31:2],2'b00}+k.
REQ-023 WR SHALL last 4 cycles; ram_wr_o = mem_sel_i[k] at step k; ram_dout_o = mem_data_i[8k+7:8k].
REQ-024 RD SHALL drive 4 address cycles plus 1 drain cycle; byte k from ram_din_i SHALL be latched into bits [8k+7:8k] one cycle after address k.
REQ-025 Latency SHALL be: read done pulse in cycle 6 after acceptance; write done pulse in cycle 5.
REQ-026 DONE SHALL last exactly one cycle, pulse only the owning port's done, then return to IDLE; a new request is accepted no earlier than the following edge.
REQ-027 stallreq_o SHALL be (if_ce_i & ~if_done_o) | (mem_ce_i & ~mem_done_o).
REQ-028 The accepted address, sel, data and port SHALL be latched at acceptance; input changes mid-transaction SHALL be ignored.
REQ-029 Address wrap: base 0xFFFFFFFC SHALL access bytes 0xFFFFFFFC..0xFFFFFFFF; the increment never carries past bit 1.
REQ-030 mem_sel_i = 4'b0000 on a write SHALL still take 4 cycles with ram_wr_o low throughout.

Reset
REQ-031 When rst is low, the block SHALL go to IDLE, clear cnt, and force all outputs to 0 immediately; ram_wr_o SHALL drop asynchronously.
REQ-032 A reset during a transaction SHALL abort it with no done pulse; a partially written word is left as is.

Configuration
REQ-033 With MEM_CTRL_FETCH_BUF_EN defined, a one-entry fetch buffer (valid, tag[31:2], word) SHALL answer a fetch whose tag matches with if_done_o in the cycle after it is sampled, without a bus access.
REQ-034 The buffer SHALL fill on every completed fetch and be invalidated by any write whose word address matches the tag, and by reset.
REQ-035 Without the macro, every fetch SHALL use the full RD sequence; no buffer storage SHALL be synthesised.

Structure
REQ-036 The shared defines header SHALL hold the state encodings, RegBus/InstAddrBus widths and a MemByteBus (8-bit) width.
REQ-037 The optional fetch buffer SHALL be a sub-module mem_fetch_buf; all other logic SHALL live in mem_ctrl.

Verification
REQ-038 Read: memory bytes 0x100..0x103 = 11,22,33,44; mem read at 0x100 -> mem_data_o = 0x44332211 with done in cycle 6; ram_a_o steps 0x100..0x103.
REQ-039 Write: addr 0x200, sel 4'b0101, data 0xAABBCCDD -> ram_wr_o high only at 0x200 (0xDD) and 0x202 (0xBB); done in cycle 5.
REQ-040 Simultaneous requests: fetch 0x0 and data read 0x10 in the same cycle -> data done first, fetch done 7 cycles later; stallreq_o high until the fetch done.
REQ-041 Reset mid-write: rst low during step 2 -> ram_wr_o low in the same cycle, no done pulse, FSM in IDLE.
REQ-042 With MEM_CTRL_FETCH_BUF_EN: fetch 0x40 twice -> second done 1 cycle after sampling; after a write to 0x40, the next fetch 0x40 takes 6 cycles and returns the new data.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: bus widths, FSM state and port encodings.
package mem_ctrl_pkg;
    localparam int RegBus      = 32;
    localparam int InstAddrBus = 32;
    localparam int MemByteBus  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        PORT_IF  = 1'b0,
        PORT_MEM = 1'b1
    } port_e;
endpackage

// File: rtl/mem_ctrl_fetch_buf.sv
// mem_fetch_buf: one-entry fetch word buffer, only built when MEM_CTRL_FETCH_BUF_EN is defined.
`ifdef MEM_CTRL_FETCH_BUF_EN
module mem_fetch_buf
    import mem_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:2]            i_lookup_tag,
    output logic                   o_hit,
    output logic [RegBus-1:0]      o_word,
    input  logic                   i_fill,
    input  logic [31:2]            i_fill_tag,
    input  logic [RegBus-1:0]      i_fill_word,
    input  logic                   i_inv,
    input  logic [31:2]            i_inv_tag
);
    logic              r_valid;
    logic [31:2]       r_tag;
    logic [RegBus-1:0] r_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_word  <= '0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_tag   <= i_fill_tag;
            r_word  <= i_fill_word;
        end else if (i_inv && (i_inv_tag == r_tag)) begin
            r_valid <= 1'b0;
        end
    end

    assign o_hit  = r_valid && (r_tag == i_lookup_tag);
    assign o_word = r_word;
endmodule
`endif

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises 32-bit fetch/data accesses into byte transfers on a byte-wide RAM.
// Optional one-entry fetch buffer enabled by defining MEM_CTRL_FETCH_BUF_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_ce_i,
    input  logic [InstAddrBus-1:0] if_addr_i,
    output logic [RegBus-1:0]      if_data_o,
    output logic                   if_done_o,
    input  logic                   mem_ce_i,
    input  logic                   mem_we_i,
    input  logic [RegBus-1:0]      mem_addr_i,
    input  logic [3:0]             mem_sel_i,
    input  logic [RegBus-1:0]      mem_data_i,
    output logic [RegBus-1:0]      mem_data_o,
    output logic                   mem_done_o,
    output logic                   stallreq_o,
    output logic [31:0]            ram_a_o,
    output logic [MemByteBus-1:0]  ram_dout_o,
    input  logic [MemByteBus-1:0]  ram_din_i,
    output logic                   ram_wr_o
);
    state_e            r_state, w_next;
    port_e             r_port;
    logic [1:0]        r_cnt;
    logic              r_drain;
    logic              r_we;
    logic [31:2]       r_addr;
    logic [3:0]        r_sel;
    logic [RegBus-1:0] r_word;

    logic              w_hit;
    logic [RegBus-1:0] w_buf_word;
    logic [1:0]        w_lat_idx;
    logic              w_rd_act, w_wr_act;
    logic              w_unused;

    assign w_unused = ^{if_addr_i[1:0], mem_addr_i[1:0]};

`ifdef MEM_CTRL_FETCH_BUF_EN
    mem_fetch_buf u_fetch_buf (
        .clk          (clk),
        .rst          (rst),
        .i_lookup_tag (if_addr_i[31:2]),
        .o_hit        (w_hit),
        .o_word       (w_buf_word),
        .i_fill       ((r_state == ST_DONE) && (r_port == PORT_IF)),
        .i_fill_tag   (r_addr),
        .i_fill_word  (r_word),
        .i_inv        (r_state == ST_WR),
        .i_inv_tag    (r_addr)
    );
`else
    assign w_hit      = 1'b0;
    assign w_buf_word = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (mem_ce_i)     w_next = mem_we_i ? ST_WR : ST_RD;
                else if (if_ce_i) w_next = w_hit ? ST_DONE : ST_RD;
            end
            ST_RD:   if (r_drain) w_next = ST_DONE;
            ST_WR:   if (r_cnt == 2'd3) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Read data lags its address by one cycle, so each RD edge stores the previous byte.
    assign w_lat_idx = r_drain ? 2'd3 : (r_cnt - 2'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_port  <= PORT_IF;
            r_cnt   <= '0;
            r_drain <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_sel   <= '0;
            r_word  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt   <= '0;
                    r_drain <= 1'b0;
                    if (mem_ce_i) begin
                        r_port <= PORT_MEM;
                        r_we   <= mem_we_i;
                        r_addr <= mem_addr_i[31:2];
                        r_sel  <= mem_sel_i;
                        r_word <= mem_data_i;
                    end else if (if_ce_i) begin
                        r_port <= PORT_IF;
                        r_we   <= 1'b0;
                        r_addr <= if_addr_i[31:2];
                        r_sel  <= '0;
                        r_word <= w_buf_word;
                    end
                end
                ST_RD: begin
                    if ((r_cnt != 2'd0) || r_drain)
                        r_word[{w_lat_idx, 3'b000} +: 8] <= ram_din_i;
                    if (!r_drain) begin
                        if (r_cnt == 2'd3) r_drain <= 1'b1;
                        else               r_cnt   <= r_cnt + 2'd1;
                    end
                end
                ST_WR:   r_cnt <= r_cnt + 2'd1;
                default: ;
            endcase
        end
    end

    assign w_rd_act = (r_state == ST_RD) && !r_drain;
    assign w_wr_act = (r_state == ST_WR);

    // Counter only replaces the low two bits, so a base near the top never carries.
    assign ram_a_o    = (w_rd_act || w_wr_act) ? {r_addr, r_cnt} : 32'd0;
    assign ram_wr_o   = w_wr_act && r_sel[r_cnt];
    assign ram_dout_o = w_wr_act ? r_word[{r_cnt, 3'b000} +: 8] : '0;

    assign if_done_o  = (r_state == ST_DONE) && (r_port == PORT_IF);
    assign mem_done_o = (r_state == ST_DONE) && (r_port == PORT_MEM);
    assign if_data_o  = if_done_o ? r_word : '0;
    assign mem_data_o = (mem_done_o && !r_we) ? r_word : '0;

    assign stallreq_o = rst && ((if_ce_i && !if_done_o) || (mem_ce_i && !mem_done_o));
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl against a byte-wide synchronous RAM model.
module tb_mem_ctrl;
    logic        clk, rst;
    logic        if_ce_i, if_done_o;
    logic [31:0] if_addr_i, if_data_o;
    logic        mem_ce_i, mem_we_i, mem_done_o, stallreq_o;
    logic [31:0] mem_addr_i, mem_data_i, mem_data_o;
    logic [3:0]  mem_sel_i;
    logic [31:0] ram_a_o;
    logic [7:0]  ram_dout_o, ram_din_i;
    logic        ram_wr_o;

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
        .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_done_o(mem_done_o),
        .stallreq_o(stallreq_o), .ram_a_o(ram_a_o), .ram_dout_o(ram_dout_o),
        .ram_din_i(ram_din_i), .ram_wr_o(ram_wr_o)
    );

`ifdef MEM_CTRL_FETCH_BUF_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 6;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];
    logic       tb_we;
    logic [9:0] tb_a;
    logic [7:0] tb_d;

    always @(posedge clk) begin
        if (tb_we)         mem[tb_a] <= tb_d;
        else if (ram_wr_o) mem[ram_a_o[9:0]] <= ram_dout_o;
        ram_din_i <= mem[ram_a_o[9:0]];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        tb_a = a; tb_d = d; tb_we = 1'b1;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    logic [31:0] a_log  [1:8];
    logic        wr_log [1:8];
    logic [7:0]  d_log  [1:8];

    // Issues one request, waits for its done pulse; lat is the cycle of done after acceptance (0 = timeout).
    task automatic do_req(input bit is_if, input bit we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat);
        bit done;
        lat = 0; rdata = '0;
        for (int i = 1; i <= 8; i++) begin a_log[i] = '0; wr_log[i] = 1'b0; d_log[i] = '0; end
        if (is_if) begin if_ce_i = 1'b1; if_addr_i = addr; end
        else begin
            mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr;
            mem_sel_i = sel; mem_data_i = wdata;
        end
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n <= 8) begin a_log[n] = ram_a_o; wr_log[n] = ram_wr_o; d_log[n] = ram_dout_o; end
            done = is_if ? if_done_o : mem_done_o;
            if (done) begin
                lat = n;
                rdata = is_if ? if_data_o : mem_data_o;
                break;
            end
        end
        @(posedge clk); #1;
        if_ce_i = 1'b0; mem_ce_i = 1'b0; mem_we_i = 1'b0;
    endtask

    logic [31:0] rd;
    int          lat, md, fd, stall_cnt, dones;
    logic        stall_at_fd;

    initial begin
        rst = 1'b0; tb_we = 1'b0; tb_a = '0; tb_d = '0;
        if_ce_i = 1'b0; if_addr_i = '0;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0; mem_data_i = '0;

        // Preload while reset is held
        poke(10'h100, 8'h11); poke(10'h101, 8'h22); poke(10'h102, 8'h33); poke(10'h103, 8'h44);
        for (int i = 0; i < 4; i++) begin
            poke(10'h200 + 10'(i), 8'h5A);
            poke(10'h300 + 10'(i), 8'h77);
            poke(10'h380 + 10'(i), 8'h00);
            poke(10'h000 + 10'(i), 8'(8'hE0 + i));
            poke(10'h010 + 10'(i), 8'(8'hC0 + i));
            poke(10'h040 + 10'(i), 8'(i + 1));
        end
        poke(10'h3FC, 8'hA1); poke(10'h3FD, 8'hB2); poke(10'h3FE, 8'hC3); poke(10'h3FF, 8'hD4);

        @(negedge clk);
        chk("rst_if_done", {31'd0, if_done_o}, 32'd0);
        chk("rst_mem_done", {31'd0, mem_done_o}, 32'd0);
        chk("rst_ram_wr", {31'd0, ram_wr_o}, 32'd0);
        chk("rst_ram_a", ram_a_o, 32'd0);
        chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // Read 0x100
        do_req(1'b0, 1'b0, 32'h100, 4'h0, 32'h0, rd, lat);
        chk("rd_data", rd, 32'h44332211);
        chk("rd_lat", lat, 32'd6);
        for (int k = 1; k <= 4; k++) chk("rd_addr", a_log[k], 32'h100 + 32'(k - 1));
        chk("rd_no_wr", {28'd0, wr_log[1], wr_log[2], wr_log[3], wr_log[4]}, 32'd0);

        // Write 0x200 sel 0101
        do_req(1'b0, 1'b1, 32'h200, 4'b0101, 32'hAABBCCDD, rd, lat);
        chk("wr_lat", lat, 32'd5);
        chk("wr_strobes", {28'd0, wr_log[1], wr_log[2], wr_log[3], wr_log[4]}, 32'b1010);
        chk("wr_a0", a_log[1], 32'h200);
        chk("wr_a2", a_log[3], 32'h202);
        chk("wr_d0", {24'd0, d_log[1]}, 32'hDD);
        chk("wr_d2", {24'd0, d_log[3]}, 32'hBB);
        do_req(1'b0, 1'b0, 32'h200, 4'h0, 32'h0, rd, lat);
        chk("wr_readback", rd, 32'h5ABB5ADD);

        // Write with no lanes enabled
        do_req(1'b0, 1'b1, 32'h303, 4'b0000, 32'h12345678, rd, lat);
        chk("sel0_lat", lat, 32'd5);
        chk("sel0_strobes", {28'd0, wr_log[1], wr_log[2], wr_log[3], wr_log[4]}, 32'd0);
        chk("sel0_mem", {mem[10'h300], mem[10'h301], mem[10'h302], mem[10'h303]}, 32'h77777777);

        // Top-of-space wrap, low address bits ignored
        do_req(1'b0, 1'b0, 32'hFFFFFFFE, 4'h0, 32'h0, rd, lat);
        chk("wrap_a0", a_log[1], 32'hFFFFFFFC);
        chk("wrap_a3", a_log[4], 32'hFFFFFFFF);
        chk("wrap_data", rd, 32'hD4C3B2A1);

        // Simultaneous fetch 0x0 and data read 0x10
        md = 0; fd = 0; stall_cnt = 0; stall_at_fd = 1'b1;
        if_ce_i = 1'b1; if_addr_i = 32'h0;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h10;
        @(posedge clk);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (mem_done_o && md == 0) begin
                md = n;
                chk("sim_mem_data", mem_data_o, 32'hC3C2C1C0);
            end
            if (if_done_o && fd == 0) begin
                fd = n; stall_at_fd = stallreq_o;
                chk("sim_if_data", if_data_o, 32'hE3E2E1E0);
            end
            if (stallreq_o) stall_cnt++;
            @(posedge clk); #1;
            if (md != 0) mem_ce_i = 1'b0;
            if (fd != 0) begin if_ce_i = 1'b0; break; end
        end
        chk("sim_mem_lat", md, 32'd6);
        chk("sim_if_gap", fd - md, 32'd7);
        chk("sim_stall_cycles", stall_cnt, 32'd12);
        chk("sim_stall_at_done", {31'd0, stall_at_fd}, 32'd0);

        // Reset during write step 2
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h380;
        mem_sel_i = 4'hF; mem_data_i = 32'h87654321;
        @(posedge clk);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("rstw_pre_wr", {31'd0, ram_wr_o}, 32'd1);
        chk("rstw_pre_a", ram_a_o, 32'h382);
        #1 rst = 1'b0;
        #1;
        chk("rstw_wr_drop", {31'd0, ram_wr_o}, 32'd0);
        chk("rstw_a_zero", ram_a_o, 32'd0);
        mem_ce_i = 1'b0; mem_we_i = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        dones = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (mem_done_o || if_done_o) dones++;
        end
        chk("rstw_no_done", dones, 32'd0);
        chk("rstw_partial", {mem[10'h383], mem[10'h382], mem[10'h381], mem[10'h380]}, 32'h00004321);
        @(posedge clk); #1;
        do_req(1'b0, 1'b0, 32'h100, 4'h0, 32'h0, rd, lat);
        chk("rstw_idle_lat", lat, 32'd6);
        chk("rstw_idle_data", rd, 32'h44332211);

        // Fetch 0x40 twice, write it, fetch again
        do_req(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, rd, lat);
        chk("fb_first_lat", lat, 32'd6);
        chk("fb_first_data", rd, 32'h04030201);
        do_req(1'b1, 1'b0, 32'h41, 4'h0, 32'h0, rd, lat);
        chk("fb_second_lat", lat, HIT_LAT);
        chk("fb_second_data", rd, 32'h04030201);
        do_req(1'b0, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D, rd, lat);
        chk("fb_wr_lat", lat, 32'd5);
        do_req(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, rd, lat);
        chk("fb_after_wr_lat", lat, 32'd6);
        chk("fb_after_wr_data", rd, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
